// File: rtl/fir_tap_sequencer.sv
// Decimating FIR tap sequencer: writes samples to an external RAM and, on every
// DECIM-th sample, runs NTAPS multiply-accumulates against an external coefficient ROM.
// Latency: y_avail NTAPS+4 cycles after the trigger edge. No backpressure: writes never stall, busy triggers set overrun.
//
// Ports:
//   clock, reset_n              - rising-edge clock, asynchronous active-low reset
//   x, x_avail                  - input sample and its one-cycle qualifier
//   ram_we/ram_waddr/ram_wdata  - sample RAM write port (combinational pass-through of x)
//   ram_raddr, ram_q            - sample RAM read port (data one cycle after address)
//   coef_addr, coef             - coefficient ROM port (registered data one cycle after address)
//   y, y_avail                  - saturated decimated output and its one-cycle qualifier
//   busy, overrun               - run in progress; sticky "trigger arrived while busy"
module fir_tap_sequencer #(
    parameter int NTAPS  = 1024,
    parameter int DECIM  = 8,
    parameter int IWIDTH = 24,
    parameter int OWIDTH = 24
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic signed [IWIDTH-1:0] x,
    input  logic                     x_avail,
    output logic                     ram_we,
    output logic [9:0]               ram_waddr,
    output logic [IWIDTH-1:0]        ram_wdata,
    output logic [9:0]               ram_raddr,
    input  logic signed [IWIDTH-1:0] ram_q,
    output logic [9:0]               coef_addr,
    input  logic signed [17:0]       coef,
    output logic signed [OWIDTH-1:0] y,
    output logic                     y_avail,
    output logic                     busy,
    output logic                     overrun
);

    localparam int PW = IWIDTH + 18;
    localparam int AW = IWIDTH + 28;
    localparam logic [9:0] KLAST = 10'(NTAPS - 1);
    localparam logic [7:0] DLAST = 8'(DECIM - 1);
    localparam logic signed [AW-1:0] YMAX = {{(AW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = {{(AW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  start;
    logic                  trigger;
    logic [9:0]            wptr;
    logic [9:0]            newest;
    logic [9:0]            k;
    logic [9:0]            k_nx;
    logic [7:0]            dcnt;
    logic [1:0]            fcnt;
    logic                  v1;
    logic                  v2;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_shr;
    logic signed [OWIDTH-1:0] y_sat;

    // Sample write path is a pure pass-through so a sample lands in RAM on the
    // same edge that counts it; the newest sample is then readable one cycle later.
    assign ram_we    = x_avail;
    assign ram_waddr = wptr;
    assign ram_wdata = x;
    assign trigger   = x_avail && (dcnt == DLAST);
    assign busy      = (state != IDLE);
    assign coef_addr = k;
    assign k_nx      = k + 10'd1;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    start    = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (k == KLAST) begin
                    state_nx = FLUSH;
                end
            end
            // Three cycles drain the RAM-read, product and accumulate stages.
            FLUSH: begin
                if (fcnt == 2'd2) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            fcnt    <= 2'd0;
            wptr    <= '0;
            dcnt    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            fcnt  <= (state == FLUSH) ? fcnt + 2'd1 : 2'd0;
            if (x_avail) begin
                wptr <= wptr + 10'd1;
                dcnt <= (dcnt == DLAST) ? 8'd0 : dcnt + 8'd1;
            end
            // OUT is not IDLE, so a trigger coinciding with OUT is an overrun too.
            if (trigger && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Address generation: k and ram_raddr are registered so they already show
    // tap k during the RUN cycle that issues it, and simply hold outside RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k         <= '0;
            newest    <= '0;
            ram_raddr <= '0;
        end else if (start) begin
            k         <= '0;
            newest    <= wptr;
            ram_raddr <= wptr;
        end else if ((state == RUN) && (k != KLAST)) begin
            k         <= k_nx;
            ram_raddr <= newest - k_nx;
        end
    end

    // v1: RAM/ROM data valid this cycle; v2: registered product valid this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= (state == RUN);
            v2 <= v1;
            if (v1) begin
                prod <= PW'(coef) * PW'(ram_q);
            end
            if (start) begin
                acc <= '0;
            end else if (v2) begin
                acc <= acc + AW'(prod);
            end
        end
    end

    // Q1.17 coefficients: drop 17 fraction bits, then clamp to the output range.
    assign acc_shr = acc >>> 17;

    always_comb begin
        y_sat = acc_shr[OWIDTH-1:0];
        if (acc_shr > YMAX) begin
            y_sat = YMAX[OWIDTH-1:0];
        end else if (acc_shr < YMIN) begin
            y_sat = YMIN[OWIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y       <= '0;
            y_avail <= 1'b0;
        end else begin
            y_avail <= (state == OUT);
            if (state == OUT) begin
                y <= y_sat;
            end
        end
    end

endmodule
